// File: rtl/cnt_cmd_seq.sv
// Command sequencer feeding the 16-bit up/down counter: turns LOAD/UP/DOWN/NOP
// commands into ld_cnt/updn_cnt/count_enb strobes. Optional macro: CNT_SEQ_PAUSE_EN adds a pause input.
module cnt_cmd_seq #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
`ifdef CNT_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic             ld_cnt,
    output logic             updn_cnt,
    output logic             count_enb,
    output logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] steps_left
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               ld_cnt_q, ld_cnt_d;
    logic               updn_cnt_q, updn_cnt_d;
    logic               count_enb_q, count_enb_d;
    logic [WIDTH-1:0]   cnt_data_q, cnt_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   steps_left_q, steps_left_d;

    logic               accept;
    logic               stall;
    logic [LEN_W-1:0]   cmd_len;

`ifdef CNT_SEQ_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    assign accept  = cmd_valid & cmd_ready_q;
    assign cmd_len = cmd_arg[LEN_W-1:0];

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = 1'b0;
        ld_cnt_d     = 1'b1;
        updn_cnt_d   = updn_cnt_q;
        count_enb_d  = 1'b0;
        cnt_data_d   = cnt_data_q;
        done_d       = 1'b0;
        steps_left_d = steps_left_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d    = ST_LOAD;
                            ld_cnt_d   = 1'b0;
                            cnt_data_d = cmd_arg;
                        end
                        OP_UP, OP_DOWN: begin
                            // Direction is latched even for a zero-length count
                            updn_cnt_d = (cmd_op == OP_UP);
                            if (cmd_len != '0) begin
                                state_d      = ST_RUN;
                                count_enb_d  = 1'b1;
                                steps_left_d = cmd_len;
                            end else begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_RUN: begin
                // Decrement only on cycles the counter actually saw an enable
                if (count_enb_q) begin
                    if (steps_left_q == LEN_W'(1)) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        steps_left_d = '0;
                    end else begin
                        steps_left_d = steps_left_q - LEN_W'(1);
                        count_enb_d  = ~stall;
                    end
                end else begin
                    count_enb_d = ~stall;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                cmd_ready_d  = 1'b1;
                steps_left_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            ld_cnt_q     <= 1'b1;
            updn_cnt_q   <= 1'b0;
            count_enb_q  <= 1'b0;
            cnt_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            steps_left_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            ld_cnt_q     <= ld_cnt_d;
            updn_cnt_q   <= updn_cnt_d;
            count_enb_q  <= count_enb_d;
            cnt_data_q   <= cnt_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            steps_left_q <= steps_left_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign ld_cnt     = ld_cnt_q;
    assign updn_cnt   = updn_cnt_q;
    assign count_enb  = count_enb_q;
    assign cnt_data   = cnt_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_left = steps_left_q;

endmodule

// File: tb/tb_cnt_cmd_seq.sv
// Self-checking bench for cnt_cmd_seq: a frame-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_cnt_cmd_seq;

    localparam int WIDTH = 16;
    localparam int LEN_W = 8;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    logic             clk;
    logic             rst_;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
`ifdef CNT_SEQ_PAUSE_EN
    logic             pause;
    logic             rand_pause;
`endif
    logic             ld_cnt;
    logic             updn_cnt;
    logic             count_enb;
    logic [WIDTH-1:0] cnt_data;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] steps_left;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    cnt_cmd_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
`ifdef CNT_SEQ_PAUSE_EN
        .pause      (pause),
`endif
        .ld_cnt     (ld_cnt),
        .updn_cnt   (updn_cnt),
        .count_enb  (count_enb),
        .cnt_data   (cnt_data),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted command expands into the list of output frames it
    // must produce, one per cycle; an empty list means the sequencer is idle and ready.
    typedef struct {
        bit ld;
        bit enb;
        bit dn;
        int steps;
    } frame_t;

    frame_t           sched[$];
    bit               m_ready = 0;
    bit               m_ld    = 1;
    bit               m_updn  = 0;
    bit               m_enb   = 0;
    logic [WIDTH-1:0] m_data  = '0;
    bit               m_busy  = 0;
    bit               m_done  = 0;
    int               m_steps = 0;
    int               acc_count = 0;
`ifdef CNT_SEQ_PAUSE_EN
    bit               m_held  = 0;
`endif

    task automatic pushFrame(input bit ld, input bit enb, input bit dn, input int steps);
        frame_t f;
        f.ld = ld; f.enb = enb; f.dn = dn; f.steps = steps;
        sched.push_back(f);
    endtask

    always @(posedge clk or negedge rst_) begin : ref_model
        frame_t f;
        int n;
        if (!rst_) begin
            m_ready = 0; m_ld = 1; m_updn = 0; m_enb = 0; m_data = '0;
            m_busy = 0; m_done = 0; m_steps = 0;
            sched.delete();
`ifdef CNT_SEQ_PAUSE_EN
            m_held = 0;
`endif
        end else begin
            if (m_ready && cmd_valid) begin
                acc_count++;
                case (cmd_op)
                    OP_LOAD: begin
                        m_data = cmd_arg;
                        pushFrame(1'b0, 1'b0, 1'b0, 0);
                    end
                    OP_UP, OP_DOWN: begin
                        m_updn = (cmd_op == OP_UP);
                        n = int'(cmd_arg[LEN_W-1:0]);
                        for (int k = n; k >= 1; k--) pushFrame(1'b1, 1'b1, 1'b0, k);
                    end
                    default: ;
                endcase
                pushFrame(1'b1, 1'b0, 1'b1, 0);
            end
`ifdef CNT_SEQ_PAUSE_EN
            if (sched.size() > 0 && pause && sched[0].enb && (m_enb || m_held)) begin
                m_enb = 0; m_ld = 1; m_done = 0; m_busy = 1; m_ready = 0;
                m_steps = sched[0].steps;
                m_held = 1;
            end else
`endif
            if (sched.size() > 0) begin
                f = sched.pop_front();
                m_ld = f.ld; m_enb = f.enb; m_done = f.dn; m_steps = f.steps;
                m_busy = 1; m_ready = 0;
`ifdef CNT_SEQ_PAUSE_EN
                m_held = 0;
`endif
            end else begin
                m_ready = 1; m_ld = 1; m_enb = 0; m_done = 0; m_steps = 0; m_busy = 0;
            end
        end
    end

    // Every cycle, on the falling edge, all outputs are compared with the model
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(m_ready));
            checkOutput("ld_cnt", 32'(ld_cnt), 32'(m_ld));
            checkOutput("updn_cnt", 32'(updn_cnt), 32'(m_updn));
            checkOutput("count_enb", 32'(count_enb), 32'(m_enb));
            checkOutput("cnt_data", 32'(cnt_data), 32'(m_data));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("steps_left", 32'(steps_left), 32'(m_steps));
        end
    end

    // Activity monitor plus a model of the downstream counter driven by the DUT strobes
    int               enb_cycles, ld_cycles, done_pulses, busy_cycles, held_cycles, held_sum;
    int               step_seq[$];
    logic [WIDTH-1:0] cnt_model = '0;

    always @(negedge clk) begin
        if (count_enb) begin
            enb_cycles++;
            step_seq.push_back(int'(steps_left));
        end
        if (!ld_cnt) ld_cycles++;
        if (done) done_pulses++;
        if (busy) busy_cycles++;
        if (busy && ld_cnt && !count_enb && !done) begin
            held_cycles++;
            held_sum += int'(steps_left);
        end
        if (!ld_cnt) cnt_model = cnt_data;
        else if (count_enb) cnt_model = updn_cnt ? cnt_model + 1'b1 : cnt_model - 1'b1;
    end

    task automatic clearMon();
        enb_cycles = 0; ld_cycles = 0; done_pulses = 0; busy_cycles = 0;
        held_cycles = 0; held_sum = 0;
        step_seq.delete();
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] arg, input bit hold);
        int start;
        bit ok;
        start = acc_count;
        ok = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (acc_count != start) begin
                ok = 1;
                break;
            end
        end
        checkOutput("accept_wait", 32'(ok), 32'd1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (cmd_ready && !busy) begin
                ok = 1;
                break;
            end
        end
        checkOutput("idle_wait", 32'(ok), 32'd1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [1:0]       op;
        logic [WIDTH-1:0] arg;
        bit               hold;

        rst_      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
`ifdef CNT_SEQ_PAUSE_EN
        pause      = 1'b0;
        rand_pause = 1'b0;
`endif
        @(negedge clk);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset_ld_cnt", 32'(ld_cnt), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_ = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

        // LOAD 1234: one-cycle load strobe, then done
        clearMon();
        applyStimulus(OP_LOAD, 16'h1234, 0);
        waitIdle();
        checkOutput("load_ld_cycles", 32'(ld_cycles), 32'd1);
        checkOutput("load_done", 32'(done_pulses), 32'd1);
        checkOutput("load_cnt_data", 32'(cnt_data), 32'h1234);
        checkOutput("load_counter", 32'(cnt_model), 32'h1234);
        checkOutput("load_busy_cycles", 32'(busy_cycles), 32'd2);

        // UP 5
        clearMon();
        applyStimulus(OP_UP, 16'h0005, 0);
        waitIdle();
        checkOutput("up5_enb_cycles", 32'(enb_cycles), 32'd5);
        checkOutput("up5_busy_cycles", 32'(busy_cycles), 32'd6);
        checkOutput("up5_updn", 32'(updn_cnt), 32'd1);
        checkOutput("up5_counter", 32'(cnt_model), 32'h1239);
        checkOutput("up5_done", 32'(done_pulses), 32'd1);
        if (step_seq.size() == 5)
            for (int i = 0; i < 5; i++) checkOutput("up5_steps_seq", 32'(step_seq[i]), 32'(5 - i));

        // DOWN 0, then NOP
        clearMon();
        applyStimulus(OP_DOWN, 16'hFF00, 0);
        waitIdle();
        checkOutput("down0_enb", 32'(enb_cycles), 32'd0);
        checkOutput("down0_ld", 32'(ld_cycles), 32'd0);
        checkOutput("down0_done", 32'(done_pulses), 32'd1);
        checkOutput("down0_busy_cycles", 32'(busy_cycles), 32'd1);
        checkOutput("down0_updn", 32'(updn_cnt), 32'd0);
        clearMon();
        applyStimulus(OP_NOP, 16'h00FF, 0);
        waitIdle();
        checkOutput("nop_enb", 32'(enb_cycles), 32'd0);
        checkOutput("nop_ld", 32'(ld_cycles), 32'd0);
        checkOutput("nop_done", 32'(done_pulses), 32'd1);
        checkOutput("nop_counter", 32'(cnt_model), 32'h1239);

        // Back-to-back with cmd_valid held: LOAD FFFF then UP 1 wraps
        clearMon();
        applyStimulus(OP_LOAD, 16'hFFFF, 1);
        applyStimulus(OP_UP, 16'h0001, 0);
        waitIdle();
        checkOutput("b2b_counter_wrap", 32'(cnt_model), 32'h0000);
        checkOutput("b2b_done", 32'(done_pulses), 32'd2);
        checkOutput("b2b_enb", 32'(enb_cycles), 32'd1);

        // Reset in the third cycle of UP 10
        clearMon();
        applyStimulus(OP_UP, 16'h000A, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_ = 1'b0;
        #1;
        checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("midrst_ld_cnt", 32'(ld_cnt), 32'd1);
        checkOutput("midrst_updn", 32'(updn_cnt), 32'd0);
        checkOutput("midrst_count_enb", 32'(count_enb), 32'd0);
        checkOutput("midrst_cnt_data", 32'(cnt_data), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_steps", 32'(steps_left), 32'd0);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst_no_done", 32'(done_pulses), 32'd0);
        checkOutput("midrst_ready_back", 32'(cmd_ready), 32'd1);
        clearMon();
        applyStimulus(OP_DOWN, 16'h0003, 0);
        waitIdle();
        checkOutput("post_rst_enb", 32'(enb_cycles), 32'd3);
        checkOutput("post_rst_done", 32'(done_pulses), 32'd1);

`ifdef CNT_SEQ_PAUSE_EN
        // UP 4 with pause sampled high on the three edges after the second enable
        clearMon();
        applyStimulus(OP_UP, 16'h0004, 0);
        @(posedge clk);
        #1;
        pause = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pause = 1'b0;
        waitIdle();
        checkOutput("pause_enb_cycles", 32'(enb_cycles), 32'd4);
        checkOutput("pause_busy_cycles", 32'(busy_cycles), 32'd8);
        checkOutput("pause_held_cycles", 32'(held_cycles), 32'd3);
        checkOutput("pause_held_steps", 32'(held_sum), 32'd6);
        checkOutput("pause_done", 32'(done_pulses), 32'd1);
        rand_pause = 1'b1;
`endif

        // Randomized commands, sometimes back-to-back
        for (int c = 0; c < 40; c++) begin
            op  = 2'($urandom_range(0, 3));
            arg = 16'($urandom);
            if (op == OP_UP || op == OP_DOWN) begin
                if ($urandom_range(0, 4) != 0) arg[LEN_W-1:0] = 8'($urandom_range(0, 6));
            end
            hold = (c != 39) && ($urandom_range(0, 1) == 1);
            applyStimulus(op, arg, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitIdle();
`ifdef CNT_SEQ_PAUSE_EN
        rand_pause = 1'b0;
        pause = 1'b0;
`endif
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

`ifdef CNT_SEQ_PAUSE_EN
    // Random pause activity during the randomized phase, including outside RUN
    always @(negedge clk) begin
        if (rand_pause) pause = ($urandom_range(0, 3) == 0);
    end
`endif

endmodule

// File: doc/cnt_cmd_seq.md
# cnt_cmd_seq

Command sequencer placed directly upstream of the 16-bit up/down counter. It accepts load/count commands over a valid/ready handshake and converts each one into the counter's control strobes: active-low load, up/down select, count enable, and load data. Count commands run for an exact number of cycles. Completion is reported with a one-cycle `done` pulse, which lets software-facing logic script counter activity without cycle-accurate timing of its own.

## Interface
- `WIDTH`, 16: counter data width; width of `cmd_arg` and `cnt_data`.
- `LEN_W`, 8: step-count width; the step count is taken from `cmd_arg[LEN_W-1:0]`.
- `clk` in 1: clock; all state changes on rising edge.
- `rst_` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command; registered.
- `cmd_op` in 2: 00 LOAD, 01 UP, 10 DOWN, 11 NOP.
- `cmd_arg` in WIDTH: load value for LOAD; step count N in the low LEN_W bits for UP/DOWN.
- `ld_cnt` out 1: active-low load strobe to the counter.
- `updn_cnt` out 1: 1 = up, 0 = down.
- `count_enb` out 1: counter enable.
- `cnt_data` out WIDTH: drives the counter data input.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `steps_left` out LEN_W: remaining enable cycles of the current count command.
- `pause` in 1: present only with `CNT_SEQ_PAUSE_EN` (see Configuration).

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
- Accept: a command is taken on any edge where `cmd_valid & cmd_ready`. `cmd_ready` is 1 only in IDLE.
- IDLE transitions on accept:
  - LOAD goes to LOAD; `cnt_data` is captured from `cmd_arg`.
  - UP or DOWN with N>0 goes to RUN; `updn_cnt` is set (1 for UP, 0 for DOWN) and `steps_left` = N.
  - UP or DOWN with N=0 goes to DONE; no enable cycles are issued.
  - NOP goes to DONE.
- LOAD: `ld_cnt`=0 for exactly 1 cycle, then DONE.
- RUN:
  - `count_enb`=1 on every non-paused cycle.
  - `steps_left` decrements on each edge where `count_enb`=1.
  - When the decrement would reach 0, the next state is DONE.
  - `count_enb` is high for exactly N cycles in total.
- DONE: `done`=1 for 1 cycle, `steps_left`=0, then IDLE with `cmd_ready`=1.
- Holding rules:
  - `updn_cnt` holds its last value outside RUN.
  - `cnt_data` holds the last load value.
  - `ld_cnt` and `count_enb` are never asserted in the same cycle.
- Arithmetic: `steps_left` is unsigned LEN_W bits, so the maximum N is 2^LEN_W−1. Bits of `cmd_arg` above LEN_W are ignored for UP/DOWN.
- Reset values: `cmd_ready`=0, `ld_cnt`=1, `updn_cnt`=0, `count_enb`=0, `cnt_data`=0, `busy`=0, `done`=0, `steps_left`=0, state IDLE.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous) and the command in flight is dropped. There is no `done` for it.

## Timing
- Accept at edge T. The first strobe (`ld_cnt`=0 or `count_enb`=1) is visible after edge T and is sampled by the counter at edge T+1.
- LOAD: strobe in cycle T..T+1, `done` in cycle T+1..T+2, `cmd_ready`=1 after edge T+2. The next accept is possible at edge T+3.
- UP/DOWN with N: `count_enb` is high in cycles T..T+N, `done` follows in the next cycle, and the next accept is at T+N+2.
- N=0 and NOP: `done` in the cycle after accept; the next accept is at T+2.
- `cmd_ready` rises on the first edge after `rst_` deasserts.
- Commands with `cmd_valid`=1 while `cmd_ready`=0 are not consumed. The source must hold the command stable until it is accepted.

## Configuration
- Macro: `CNT_SEQ_PAUSE_EN`.
- Defined:
  - The `pause` input exists.
  - In RUN, `pause` sampled high at edge E forces `count_enb`=0 after E.
  - `steps_left` and the state hold while paused; counting resumes one cycle after `pause` falls.
  - `pause` has no effect outside RUN.
  - The total number of enable cycles is still exactly N.
- Undefined: the port is absent and RUN never stalls.

## Test plan
- Reset, then LOAD with `cmd_arg`=16'h1234 → `ld_cnt` low for exactly 1 cycle with `cnt_data`=16'h1234; `done` pulse the next cycle; `cmd_ready`=1 after that.
- UP with N=5 → `updn_cnt`=1; `count_enb` high for exactly 5 consecutive cycles; `steps_left` goes 5,4,3,2,1; then `done` pulse; a counter model starting at 16'h1234 ends at 16'h1239.
- DOWN with N=0, then NOP → no `count_enb` and no `ld_cnt`; each produces a `done` one cycle after accept; `updn_cnt`=0 after the DOWN.
- `cmd_valid` held high with back-to-back LOAD 16'hFFFF then UP with N=1 → the second command is accepted only when `cmd_ready`=1; a counter model shows wrap to 16'h0000.
- Assert `rst_` low at the third cycle of UP with N=10 → all outputs at reset values immediately; no `done`; after release `cmd_ready`=1 and a new command completes normally.
- With `CNT_SEQ_PAUSE_EN`: UP with N=4, `pause` high for 3 cycles after the second enable → exactly 4 enable cycles total; `steps_left` holds at 2 during the pause; `done` is delayed by 3 cycles.
